// File: rtl/apb_master_if.sv
// apb_master_if: controller command/response channel plus APB bus driven by apb_master
// ports: none; master modport = apb_master view, slave modport = controller and APB slave view
interface apb_master_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              p_sel;
  logic              p_enable;
  logic              p_write;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_w_data;
  logic              p_ready;
  logic              p_slv_err;
  logic [DATA_W-1:0] p_r_data;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, p_ready, p_slv_err, p_r_data,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           p_sel, p_enable, p_write, p_addr, p_w_data
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, p_ready, p_slv_err, p_r_data,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           p_sel, p_enable, p_write, p_addr, p_w_data
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: APB initiator turning single-shot commands into APB transfers with wait-state timeout
// ports: p_clk bus clock; p_rst sync active-high reset; bus = command in, response out, APB bus out
module apb_master #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic         p_clk,
  input logic         p_rst,
  apb_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t            state_q;
  logic [7:0]        wait_cnt_q;
  logic              cmd_ready_q, rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic              p_sel_q, p_enable_q, p_write_q;
  logic [ADDR_W-1:0] p_addr_q;
  logic [DATA_W-1:0] p_w_data_q, rsp_rdata_q;
  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      p_sel_q       <= 1'b0;
      p_enable_q    <= 1'b0;
      p_write_q     <= 1'b0;
      p_addr_q      <= '0;
      p_w_data_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.cmd_valid) begin
          state_q     <= SETUP;
          wait_cnt_q  <= '0;
          cmd_ready_q <= 1'b0;
          p_sel_q     <= 1'b1;
          p_enable_q  <= 1'b0;
          p_write_q   <= bus.cmd_write;
          p_addr_q    <= bus.cmd_addr;
          p_w_data_q  <= bus.cmd_write ? bus.cmd_wdata : '0;
        end
        SETUP: begin
          state_q    <= ACCESS;
          p_enable_q <= 1'b1;
        end
        ACCESS: if (bus.p_ready) begin
          state_q       <= IDLE;
          cmd_ready_q   <= 1'b1;
          p_sel_q       <= 1'b0;
          p_enable_q    <= 1'b0;
          rsp_valid_q   <= 1'b1;
          rsp_err_q     <= bus.p_slv_err;
          rsp_timeout_q <= 1'b0;
          rsp_rdata_q   <= p_write_q ? '0 : bus.p_r_data;
        end else begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          if (TIMEOUT != 0 && wait_cnt_q == TO_LAST) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            p_sel_q       <= 1'b0;
            p_enable_q    <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.p_sel       = p_sel_q;
  assign bus.p_enable    = p_enable_q;
  assign bus.p_write     = p_write_q;
  assign bus.p_addr      = p_addr_q;
  assign bus.p_w_data    = p_w_data_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed self-checking bench for apb_master
module tb_apb_master;
  logic p_clk = 1'b0;
  logic p_rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  apb_master_if #(.ADDR_W(2), .DATA_W(32)) bus ();
  apb_master #(.ADDR_W(2), .DATA_W(32), .TIMEOUT(16)) dut (.p_clk(p_clk), .p_rst(p_rst), .bus(bus));
  always #5 p_clk = ~p_clk;
  task automatic step();
    @(posedge p_clk);
    @(negedge p_clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic w, input logic [1:0] a, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    step();
    bus.cmd_valid = 1'b0;
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.p_ready   = 1'b1;
    bus.p_slv_err = 1'b0;
    bus.p_r_data  = '0;
    @(negedge p_clk);
    step();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_p_sel", 32'(bus.p_sel), 32'd0);
    chk("rst_p_enable", 32'(bus.p_enable), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_p_addr", 32'(bus.p_addr), 32'd0);
    chk("rst_p_w_data", bus.p_w_data, 32'd0);
    p_rst = 1'b0;
    step();
    // zero-wait write
    send(1'b1, 2'b10, 32'd16);
    chk("wr_setup_sel", 32'(bus.p_sel), 32'd1);
    chk("wr_setup_en", 32'(bus.p_enable), 32'd0);
    chk("wr_setup_ready", 32'(bus.cmd_ready), 32'd0);
    chk("wr_setup_write", 32'(bus.p_write), 32'd1);
    chk("wr_setup_addr", 32'(bus.p_addr), 32'd2);
    chk("wr_setup_wdata", bus.p_w_data, 32'd16);
    step();
    chk("wr_access_en", 32'(bus.p_enable), 32'd1);
    chk("wr_access_rspv", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wr_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("wr_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("wr_done_sel", 32'(bus.p_sel), 32'd0);
    chk("wr_done_ready", 32'(bus.cmd_ready), 32'd1);
    chk("wr_hold_addr", 32'(bus.p_addr), 32'd2);
    step();
    chk("wr_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    // zero-wait read returning 16
    bus.p_r_data = 32'd16;
    send(1'b0, 2'b10, 32'hFFFF_FFFF);
    chk("rd_setup_write", 32'(bus.p_write), 32'd0);
    chk("rd_setup_wdata", bus.p_w_data, 32'd0);
    step();
    chk("rd_access_write", 32'(bus.p_write), 32'd0);
    chk("rd_access_en", 32'(bus.p_enable), 32'd1);
    step();
    chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'd16);
    step();
    // three wait states
    bus.p_ready = 1'b0;
    bus.p_r_data = 32'h0000_A5A5;
    send(1'b0, 2'b01, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("wait_sel", 32'(bus.p_sel), 32'd1);
      chk("wait_en", 32'(bus.p_enable), 32'd1);
      chk("wait_addr", 32'(bus.p_addr), 32'd1);
      chk("wait_rspv", 32'(bus.rsp_valid), 32'd0);
      step();
    end
    chk("wait_last_en", 32'(bus.p_enable), 32'd1);
    chk("wait_last_rspv", 32'(bus.rsp_valid), 32'd0);
    bus.p_ready = 1'b1;
    step();
    chk("wait_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wait_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("wait_rsp_rdata", bus.rsp_rdata, 32'h0000_A5A5);
    step();
    // slave error, back-to-back command
    bus.p_slv_err = 1'b1;
    send(1'b1, 2'b11, 32'h0000_DEAD);
    step();
    step();
    chk("err_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("err_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("err_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    chk("err_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.p_slv_err = 1'b0;
    bus.p_r_data = 32'd7;
    send(1'b0, 2'b00, 32'd0);
    chk("b2b_sel", 32'(bus.p_sel), 32'd1);
    chk("b2b_ready", 32'(bus.cmd_ready), 32'd0);
    chk("b2b_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("b2b_addr", 32'(bus.p_addr), 32'd0);
    step();
    step();
    chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("b2b_rsp_rdata", bus.rsp_rdata, 32'd7);
    chk("b2b_rsp_err", 32'(bus.rsp_err), 32'd0);
    step();
    // timeout: 16 ACCESS cycles with p_ready low
    bus.p_ready = 1'b0;
    bus.p_r_data = 32'hFFFF_FFFF;
    send(1'b0, 2'b10, 32'd0);
    step();
    for (int i = 0; i < 15; i++) begin
      chk("to_wait_rspv", 32'(bus.rsp_valid), 32'd0);
      step();
    end
    chk("to_last_sel", 32'(bus.p_sel), 32'd1);
    chk("to_last_rspv", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("to_rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
    chk("to_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("to_p_sel", 32'(bus.p_sel), 32'd0);
    chk("to_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    step();
    // reset during ACCESS
    send(1'b1, 2'b01, 32'd5);
    step();
    chk("rst_mid_en", 32'(bus.p_enable), 32'd1);
    p_rst = 1'b1;
    step();
    chk("rst_mid_sel", 32'(bus.p_sel), 32'd0);
    chk("rst_mid_en0", 32'(bus.p_enable), 32'd0);
    chk("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_mid_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid_addr", 32'(bus.p_addr), 32'd0);
    chk("rst_mid_timeout", 32'(bus.rsp_timeout), 32'd0);
    p_rst = 1'b0;
    bus.p_ready = 1'b1;
    step();
    chk("rst_after_rspv", 32'(bus.rsp_valid), 32'd0);
    bus.p_r_data = 32'h0000_1234;
    send(1'b0, 2'b11, 32'd0);
    step();
    step();
    chk("post_rst_rspv", 32'(bus.rsp_valid), 32'd1);
    chk("post_rst_rdata", bus.rsp_rdata, 32'h0000_1234);
    chk("post_rst_err", 32'(bus.rsp_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
